fx_mul_pipe: RTL
================

# fx_mul_pipe

Pipelined, parametrised signed fixed-point multiplier with rounding and symmetric saturation. It accepts operand pairs over a valid/ready handshake and returns the scaled, rounded, saturated product a fixed number of cycles later. Back-pressure stalls the whole pipeline. It is the multiply stage of the fixed-point MAC datapath and replaces the single-shot, edge-triggered 16-bit multiplier.

## Interface
- W, 16: operand and result width in bits, two's complement; legal range 4..32.
- FRAC, 9: number of fractional bits in operands and result; legal range 1..W-1.
- STAGES, 2: pipeline depth (register stages from input to output); legal range 1..4.
- ROUND, 1: rounding mode. 1 = round half toward +inf. 0 = truncate toward -inf.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  the block accepts the pair this cycle.
- in_a  in  W  signed multiplicand.
- in_b  in  W  signed multiplier.
- out_valid  out  1  result present.
- out_ready  in  1  the consumer accepts the result this cycle.
- out_data  out  W  signed result.
- out_sat  out  1  the result was saturated.

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - During a stall, every stage register and its valid bit hold.
- Product: P = in_a * in_b as a signed 2W-bit value, exact.
- Scaling:
  - ROUND=1: R = (P + 2^(FRAC-1)) >>> FRAC.
  - ROUND=0: R = P >>> FRAC.
  - Both use an arithmetic shift. Intermediates are at least 2W+1 bits, so the rounding add cannot wrap.
- Saturation is symmetric. Define MAX = 2^(W-1)-1.
  - R > MAX: out_data = MAX, out_sat = 1.
  - R < -MAX: out_data = -MAX, out_sat = 1. For W=16 this is 0x8001; the value -2^(W-1) is never produced.
  - Otherwise: out_data = R[W-1:0], out_sat = 0.
- Pipeline placement:
  - Stage 1 registers P.
  - Stages 2..STAGES-1 carry P forward.
  - The last stage registers the rounded, saturated result.
  - With STAGES=1, multiply, round and saturate all complete before the single register.
- Valid tracking: one valid bit per stage. A bubble (no input transfer) enters as valid=0.
- Data path gating: data registers in invalid stages may hold any value. out_data and out_sat are only meaningful while out_valid=1.
- Results leave in acceptance order. There is no dropping or duplication.

## Timing
- Reset (asynchronous, rst_n low):
  - All valid bits clear immediately.
  - out_valid = 0, out_data = 0, out_sat = 0.
  - in_ready = 1.
- Reset mid-operation: all in-flight operations are discarded and no result is emitted for them. The first input accepted after rst_n deasserts produces the first result.
- Latency: an input accepted at edge k appears at out_valid after edge k+STAGES-1, provided no stall occurs in between. Every stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous events:
  - When out_ready=1 with out_valid=1, the pipe advances in the same cycle and in_ready=1. A new input is accepted in the same cycle the oldest result leaves.
  - When out_valid=0, the pipe advances regardless of out_ready. Bubbles collapse only at the output.
- Protocol hold: the producer holds in_a/in_b stable while in_valid=1 and in_ready=0. The block holds out_data/out_sat stable while stalled.

## Test plan
All scenarios use W=16, FRAC=9, STAGES=2 unless stated.
- Basic multiply: in_a=0x0200 (1.0), in_b=0x0300 (1.5) -> out_data=0x0300, out_sat=0; out_valid rises at the edge after acceptance.
- Saturation:
  - 0x7FFF*0x7FFF -> out_data=0x7FFF, out_sat=1.
  - 0x8000*0x7FFF -> out_data=0x8001, out_sat=1.
  - 0x8000*0x8000 -> out_data=0x7FFF, out_sat=1.
- Rounding:
  - ROUND=1: 0x0001*0x0100 -> 0x0001; 0xFFFF*0x0100 -> 0x0000.
  - ROUND=0: the same pairs give 0x0000 and 0xFFFF respectively.
- Back-pressure: stream 8 random pairs with in_valid=1 continuously, holding out_ready=0 for 3 cycles mid-stream.
  - in_ready drops whenever out_valid=1 and out_ready=0.
  - All 8 results emerge in order, matching the reference model bit-exactly, with no loss or duplication.
- Reset mid-stream: assert rst_n low for 1 cycle with 2 operations in flight.
  - out_valid=0 and out_data=0 immediately.
  - Neither in-flight result ever appears.
  - The next accepted pair yields its result after nominal latency.
- Parameter sweep: repeat a random 1000-vector compare for (W,FRAC,STAGES) in (8,4,1), (16,15,3) and (32,16,4), for both ROUND settings. Results, including out_sat, are bit-exact to the model.

Source files
------------

// File: rtl/fx_mul_pipe.sv
// Pipelined signed fixed-point multiplier: exact product, scale by FRAC with optional
// round-half-up, then symmetric saturation. A stalled output freezes the whole pipe.
module fx_mul_pipe #(
  parameter int unsigned W      = 16,
  parameter int unsigned FRAC   = 9,
  parameter int unsigned STAGES = 2,
  parameter int unsigned ROUND  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_sat
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned XW = PW + 1;
  localparam int unsigned NP = (STAGES > 1) ? STAGES - 1 : 1;

  localparam logic signed [XW-1:0] RND_C = (ROUND != 0) ? (XW'(1) << (FRAC - 1)) : XW'(0);
  localparam logic signed [XW-1:0] MAX_C = (XW'(1) << (W - 1)) - XW'(1);
  localparam logic signed [XW-1:0] MIN_C = -MAX_C;

  logic                 stall_c;
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] p_last_c;
  logic signed [XW-1:0] rsum_c;
  logic signed [XW-1:0] rshift_c;
  logic [W-1:0]         res_data_c;
  logic                 res_sat_c;

  logic [STAGES-1:0]    valid_q, valid_d;
  logic signed [PW-1:0] p_q [NP];
  logic signed [PW-1:0] p_d [NP];
  logic [W-1:0]         data_q, data_d;
  logic                 sat_q, sat_d;

  assign stall_c   = valid_q[STAGES-1] && !out_ready;
  assign in_ready  = !stall_c;
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q;
  assign out_sat   = sat_q;

  assign prod_c   = $signed({{W{in_a[W-1]}}, in_a}) * $signed({{W{in_b[W-1]}}, in_b});
  assign p_last_c = (STAGES > 1) ? p_q[NP-1] : prod_c;

  // One extra guard bit keeps the rounding add from wrapping before the shift.
  always_comb begin
    rsum_c     = $signed({p_last_c[PW-1], p_last_c}) + RND_C;
    rshift_c   = rsum_c >>> FRAC;
    res_data_c = rshift_c[W-1:0];
    res_sat_c  = 1'b0;
    if (rshift_c > MAX_C) begin
      res_data_c = MAX_C[W-1:0];
      res_sat_c  = 1'b1;
    end else if (rshift_c < MIN_C) begin
      res_data_c = MIN_C[W-1:0];
      res_sat_c  = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    p_d     = p_q;
    data_d  = data_q;
    sat_d   = sat_q;
    if (!stall_c) begin
      valid_d[0] = in_valid;
      for (int unsigned i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
      end
      if (STAGES > 1) begin
        p_d[0] = prod_c;
        for (int unsigned i = 1; i < NP; i++) begin
          p_d[i] = p_q[i-1];
        end
      end
      data_d = res_data_c;
      sat_d  = res_sat_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      for (int unsigned i = 0; i < NP; i++) begin
        p_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      p_q     <= p_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

endmodule
